// File: rtl/wb_data_pipe_if.sv
// Memory-side bus of the write-back stage: one outstanding request, completed by a one-cycle ack.
interface wb_data_pipe_if;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_miss;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata, mem_miss
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata, mem_miss
    );
endinterface

// File: rtl/wb_data_pipe.sv
// Write-back stage: issues one load/store to memory, stalls until it completes or times out,
// extends load data, and keeps hit/miss/stall performance counters.
module wb_data_pipe #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubbleW,
    input  logic             flushW,
    input  logic             wb_select,
    input  logic [2:0]       load_type,
    input  logic [3:0]       write_en,
    input  logic [31:0]      addr,
    input  logic [31:0]      in_data,
    wb_data_pipe_if.master   mem,
    output logic             stall_req,
    output logic [31:0]      data_WB,
    output logic             misalign,
    output logic             timeout_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic        present, ack_done, timed_out;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_we;
    logic [1:0]  req_off;
    logic [2:0]  req_lt;
    logic        req_load;
    logic        flush_pend;
    logic [15:0] wait_cnt;

    function automatic logic [31:0] load_extend(input logic [2:0] lt, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (lt)
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {{24{b[7]}}, b};
            3'b011:  return {16'b0, h};
            3'b100:  return {24'b0, b};
            default: return word;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic ld, input logic [2:0] lt,
                                           input logic [3:0] we, input logic [1:0] off);
        if (ld) begin
            case (lt)
                3'b001, 3'b011: return off[0];
                3'b010, 3'b100: return 1'b0;
                default:        return off != 2'b00;
            endcase
        end
        case (we)
            4'b1111:         return off != 2'b00;
            4'b0011, 4'b1100: return off[0];
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave a latch behind.
        state_nxt = state;
        present   = 1'b0;
        ack_done  = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                present = !bubbleW && !flushW && (wb_select || write_en != 4'b0000);
                if (present) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_req     = !rst && (present || (state == WAIT && !mem.mem_ack));
    assign misalign      = !rst && present && is_misaligned(wb_select, load_type, write_en, addr[1:0]);
    assign mem.mem_req   = (state == WAIT);
    assign mem.mem_we    = (state == WAIT) ? req_we : 4'b0000;
    assign mem.mem_addr  = req_addr;
    assign mem.mem_wdata = req_wdata;

    // A flush seen at any point of the transaction discards its result but never aborts the bus cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_we     <= '0;
            req_off    <= '0;
            req_lt     <= '0;
            req_load   <= 1'b0;
            flush_pend <= 1'b0;
            wait_cnt   <= '0;
            data_WB    <= '0;
        end else begin
            if (present) begin
                req_addr   <= {addr[31:2], 2'b00};
                req_off    <= addr[1:0];
                req_wdata  <= in_data;
                req_we     <= wb_select ? 4'b0000 : write_en;
                req_lt     <= load_type;
                req_load   <= wb_select;
                flush_pend <= 1'b0;
            end else if (state == WAIT) begin
                flush_pend <= flush_pend | flushW;
            end

            wait_cnt <= (state == WAIT && !mem.mem_ack && !timed_out) ? wait_cnt + 1'b1 : '0;

            if (ack_done) begin
                if (flush_pend || flushW) data_WB <= '0;
                else if (req_load)        data_WB <= load_extend(req_lt, req_off, mem.mem_rdata);
                else                      data_WB <= {req_addr[31:2], req_off};
            end else if (timed_out) begin
                data_WB <= '0;
            end else if (state == IDLE && !present && !bubbleW) begin
                data_WB <= flushW ? 32'b0 : addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (ack_done && !mem.mem_miss) hit_cnt  <= sat_inc(hit_cnt);
            if (ack_done && mem.mem_miss)  miss_cnt <= sat_inc(miss_cnt);
            if (stall_req)                 stall_cnt <= sat_inc(stall_cnt);
            if (timed_out)                 timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_data_pipe.sv
// Bench for wb_data_pipe: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed results.
module tb_wb_data_pipe;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bubbleW = 1'b0, flushW = 1'b0, wb_select = 1'b0, cnt_clr = 1'b0;
    logic [2:0]       load_type = 3'b000;
    logic [3:0]       write_en = 4'b0000;
    logic [31:0]      addr = '0, in_data = '0;
    logic             stall_req, misalign, timeout_err;
    logic [31:0]      data_WB;
    logic [CNT_W-1:0] hit_cnt, miss_cnt, stall_cnt;

    wb_data_pipe_if bus();

    wb_data_pipe #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .bubbleW(bubbleW), .flushW(flushW), .wb_select(wb_select),
        .load_type(load_type), .write_en(write_en), .addr(addr), .in_data(in_data),
        .mem(bus), .stall_req(stall_req), .data_WB(data_WB), .misalign(misalign),
        .timeout_err(timeout_err), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction, tracked by its captured request and cycles waited.
    bit          m_busy, m_ld, m_flushed, m_tmo;
    logic [31:0] m_addr, m_data, m_wb;
    logic [3:0]  m_we;
    logic [2:0]  m_lt;
    int          m_waited, m_hit, m_miss, m_stall;

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    function automatic int acc_bytes(input logic ld, input logic [2:0] lt, input logic [3:0] we);
        if (ld) begin
            if (lt == 3'b001 || lt == 3'b011) return 2;
            if (lt == 3'b010 || lt == 3'b100) return 1;
            return 4;
        end
        if (we == 4'b1111) return 4;
        if (we == 4'b0011 || we == 4'b1100) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] word);
        logic [31:0] sw;
        int sh;
        if (lt == 3'b010 || lt == 3'b100)      sh = off * 8;
        else if (lt == 3'b001 || lt == 3'b011) sh = (off & 2'b10) * 8;
        else                                   sh = 0;
        sw = word >> sh;
        case (lt)
            3'b010:  return 32'($signed(sw[7:0]));
            3'b100:  return sw & 32'h0000_00FF;
            3'b001:  return 32'($signed(sw[15:0]));
            3'b011:  return sw & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic bit f_present();
        return !m_busy && !bubbleW && !flushW && (wb_select || write_en != 4'b0000);
    endfunction

    function automatic bit f_ack();
        return m_busy && bus.mem_ack;
    endfunction

    function automatic bit f_tmo();
        return m_busy && !bus.mem_ack && (m_waited + 1 >= MAX_WAIT);
    endfunction

    function automatic bit exp_stall();
        return !rst && (f_present() || (m_busy && !bus.mem_ack));
    endfunction

    function automatic logic [31:0] f_next_wb();
        if (f_ack()) begin
            if (m_flushed || flushW) return 32'b0;
            return m_ld ? extend(m_lt, m_addr[1:0], bus.mem_rdata) : m_addr;
        end
        if (m_busy)      return f_tmo() ? 32'b0 : m_wb;
        if (bubbleW)     return m_wb;
        if (flushW)      return 32'b0;
        if (f_present()) return m_wb;
        return addr;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_ld <= 1'b0; m_flushed <= 1'b0; m_tmo <= 1'b0;
            m_addr <= '0; m_data <= '0; m_wb <= '0; m_we <= '0; m_lt <= '0;
            m_waited <= 0; m_hit <= 0; m_miss <= 0; m_stall <= 0;
        end else begin
            m_wb     <= f_next_wb();
            m_hit    <= cnt_clr ? 0 : (f_ack() && !bus.mem_miss) ? sat(m_hit + 1) : m_hit;
            m_miss   <= cnt_clr ? 0 : (f_ack() && bus.mem_miss) ? sat(m_miss + 1) : m_miss;
            m_stall  <= cnt_clr ? 0 : exp_stall() ? sat(m_stall + 1) : m_stall;
            m_tmo    <= cnt_clr ? 1'b0 : (f_tmo() ? 1'b1 : m_tmo);
            m_waited <= (m_busy && !bus.mem_ack && !f_tmo()) ? m_waited + 1 : 0;
            if (f_present()) begin
                m_busy    <= 1'b1;
                m_addr    <= addr;
                m_data    <= in_data;
                m_we      <= write_en;
                m_lt      <= load_type;
                m_ld      <= wb_select;
                m_flushed <= 1'b0;
            end else begin
                if (f_ack() || f_tmo()) m_busy <= 1'b0;
                m_flushed <= m_busy && (m_flushed || flushW);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_stall_req", stall_req, exp_stall());
            check("cyc_misalign", misalign,
                  !rst && f_present() && (addr % acc_bytes(wb_select, load_type, write_en)) != 0);
            check("cyc_mem_req", bus.mem_req, m_busy);
            check("cyc_mem_we", bus.mem_we, (m_busy && !m_ld) ? m_we : 4'b0000);
            if (m_busy) begin
                check("cyc_mem_addr", bus.mem_addr, m_addr & 32'hFFFF_FFFC);
                check("cyc_mem_wdata", bus.mem_wdata, m_data);
            end
            check("cyc_data_WB", data_WB, m_wb);
            check("cyc_hit_cnt", hit_cnt, m_hit);
            check("cyc_miss_cnt", miss_cnt, m_miss);
            check("cyc_stall_cnt", stall_cnt, m_stall);
            check("cyc_timeout_err", timeout_err, m_tmo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        wb_select = 1'b0; write_en = 4'b0000; flushW = 1'b0; bubbleW = 1'b0;
        addr = '0; in_data = '0;
    endtask

    // Presents one access, waits 'waits' cycles without ack, then acks; flushW is raised in WAIT cycle 'flush_at'.
    task automatic access(input logic ld, input logic [2:0] lt, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d, input int waits,
                          input int flush_at, input logic [31:0] rdata, input logic miss,
                          output int stalls, output int misals, output int reqs,
                          output logic [31:0] wb, output logic [31:0] first_addr,
                          output logic [3:0] first_we);
        wb_select = ld; load_type = lt; write_en = we; addr = a; in_data = d;
        stalls = 0; misals = 0; reqs = 0;
        #1;
        stalls += int'(stall_req);
        misals += int'(misalign);
        step();
        go_idle();
        first_addr = bus.mem_addr;
        first_we   = bus.mem_we;
        for (int k = 1; k <= waits + 1; k++) begin
            flushW = (k == flush_at);
            if (k == waits + 1) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = rdata; bus.mem_miss = miss;
            end
            #1;
            stalls += int'(stall_req);
            misals += int'(misalign);
            reqs   += int'(bus.mem_req);
            step();
        end
        bus.mem_ack = 1'b0; bus.mem_miss = 1'b0; flushW = 1'b0;
        wb = data_WB;
    endtask

    int          st, ms, rq;
    logic [31:0] wbv, fa;
    logic [3:0]  fw;

    logic [2:0]  t_lt  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};
    logic [31:0] t_a   [5] = '{32'h10, 32'h12, 32'h11, 32'h10, 32'h20};
    logic [31:0] t_rd  [5] = '{32'hDEAD_BEEF, 32'h8001_7FFF, 32'h1234_56F0, 32'h0000_00F0, 32'hCAFE_F00D};
    logic [31:0] t_exp [5] = '{32'hDEAD_BEEF, 32'hFFFF_8001, 32'h0000_0056, 32'h0000_00F0, 32'hCAFE_F00D};

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_miss = 1'b0;
        step();
        armed = 1'b1;
        step();
        check("rst_data_WB", data_WB, 32'h0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 4'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_stall_req", stall_req, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_counters", {hit_cnt, miss_cnt, stall_cnt}, 32'h0);
        rst = 1'b0;

        // LB with sign extension, three stall cycles, a miss
        access(1'b1, 3'b010, 4'b0000, 32'h1003, 32'h0, 2, 0, 32'h80FF_FF7F, 1'b1, st, ms, rq, wbv, fa, fw);
        check("lb_data", wbv, 32'hFFFF_FF80);
        check("lb_stall_cycles", st, 3);
        check("lb_miss_cnt", miss_cnt, 1);
        check("lb_stall_cnt", stall_cnt, 3);

        // LHU, one-cycle memory, hit
        access(1'b1, 3'b011, 4'b0000, 32'h2002, 32'h0, 0, 0, 32'hBEEF_1234, 1'b0, st, ms, rq, wbv, fa, fw);
        check("lhu_data", wbv, 32'h0000_BEEF);
        check("lhu_hit_cnt", hit_cnt, 1);

        // Misaligned word store still proceeds
        access(1'b0, 3'b000, 4'b1111, 32'h3001, 32'hA5A5_5A5A, 0, 0, 32'h0, 1'b0, st, ms, rq, wbv, fa, fw);
        check("st_misalign_pulses", ms, 1);
        check("st_mem_addr", fa, 32'h3000);
        check("st_mem_we", fw, 4'b1111);
        check("st_data", wbv, 32'h3001);

        // Flush in the second WAIT cycle: bus cycle completes, result discarded
        access(1'b1, 3'b000, 4'b0000, 32'h50, 32'h0, 3, 2, 32'h1234_5678, 1'b0, st, ms, rq, wbv, fa, fw);
        check("fl_req_cycles", rq, 4);
        check("fl_data", wbv, 32'h0);
        check("fl_hit_cnt", hit_cnt, 3);
        check("fl_stall_cnt", stall_cnt, 9);

        // Timeout after MAX_WAIT cycles, late ack ignored, clear
        wb_select = 1'b1; load_type = 3'b000; addr = 32'h4000;
        step();
        go_idle();
        repeat (3) step();
        check("to_still_waiting", bus.mem_req, 1'b1);
        step();
        check("to_idle", bus.mem_req, 1'b0);
        check("to_err", timeout_err, 1'b1);
        check("to_data", data_WB, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF; bus.mem_miss = 1'b0;
        step();
        bus.mem_ack = 1'b0;
        check("late_hit_cnt", hit_cnt, 3);
        check("late_miss_cnt", miss_cnt, 1);
        check("late_data", data_WB, 32'h0);
        check("late_stall_cnt", stall_cnt, 14);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_err", timeout_err, 1'b0);
        check("clr_counters", {hit_cnt, miss_cnt, stall_cnt}, 32'h0);

        // Clear wins over simultaneous increments
        wb_select = 1'b1; load_type = 3'b000; addr = 32'h60; cnt_clr = 1'b1;
        #1;
        check("clrw_stall_req", stall_req, 1'b1);
        step();
        go_idle();
        check("clrw_stall_cnt", stall_cnt, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11;
        step();
        bus.mem_ack = 1'b0; cnt_clr = 1'b0;
        check("clrw_hit_cnt", hit_cnt, 0);
        check("clrw_data", data_WB, 32'h11);

        // Stall counter saturates
        for (int i = 0; i < 4; i++) begin
            wb_select = 1'b1; load_type = 3'b000; addr = 32'h70;
            step();
            go_idle();
            repeat (4) step();
        end
        check("sat_stall_cnt", stall_cnt, 15);

        // ALU path with bubble/flush priority
        addr = 32'h77;
        step();
        check("alu_data", data_WB, 32'h77);
        addr = 32'h55; bubbleW = 1'b1; flushW = 1'b1;
        step();
        check("alu_bubble_hold", data_WB, 32'h77);
        bubbleW = 1'b0;
        step();
        check("alu_flush_zero", data_WB, 32'h0);
        flushW = 1'b0;
        step();
        check("alu_pass", data_WB, 32'h55);
        wb_select = 1'b1; flushW = 1'b1; addr = 32'h88;
        #1;
        check("flushed_acc_stall", stall_req, 1'b0);
        step();
        check("flushed_acc_no_req", bus.mem_req, 1'b0);
        go_idle();

        // Load extension table
        for (int i = 0; i < 5; i++) begin
            access(1'b1, t_lt[i], 4'b0000, t_a[i], 32'h0, 1, 0, t_rd[i], 1'b0, st, ms, rq, wbv, fa, fw);
            check($sformatf("ld_tab_%0d", i), wbv, t_exp[i]);
        end

        // Reset abandons an in-flight transaction
        wb_select = 1'b1; load_type = 3'b000; addr = 32'h90;
        step();
        go_idle();
        check("rw_req", bus.mem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rw_stall_low", stall_req, 1'b0);
        step();
        rst = 1'b0;
        check("rw_req_dropped", bus.mem_req, 1'b0);
        check("rw_data", data_WB, 32'h0);
        check("rw_counters", {hit_cnt, miss_cnt, stall_cnt}, 32'h0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_data_pipe.md
WB_DATA_PIPE -- requirements
Module: wb_data_pipe

Interface
REQ-001 Parameters SHALL be: CNT_W, default 32, width of performance counters; MAX_WAIT, default 255, memory-wait cycles before timeout (1..65535).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- bubbleW  in  1  hold WB stage.
- flushW  in  1  clear WB stage.
- wb_select  in  1  1 = load result, 0 = ALU result (addr).
- load_type  in  3  000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU; others treated as LW.
- write_en  in  4  store byte enables, already lane-positioned.
- addr  in  32  memory address / ALU result.
- in_data  in  32  store data.
- mem_req  out  1  memory request.
- mem_we  out  4  request byte enables, 0 = read.
- mem_addr  out  32  word-aligned request address.
- mem_wdata  out  32  request store data.
- mem_ack  in  1  request complete, one-cycle pulse.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_miss  in  1  access missed, valid with mem_ack.
- stall_req  out  1  stall request to the hazard unit.
- data_WB  out  32  write-back data.
- misalign  out  1  one-cycle misaligned-access pulse.
- timeout_err  out  1  sticky timeout flag.
- cnt_clr  in  1  synchronous counter clear.
- hit_cnt, miss_cnt, stall_cnt  out  CNT_W  performance counters.

Function
REQ-003 The FSM SHALL have states IDLE and WAIT.
REQ-004 An access SHALL be presented when the FSM is in IDLE, bubbleW=0, flushW=0, and (wb_select=1 or write_en!=0).
REQ-005 On presentation: addr, in_data, write_en, load_type and wb_select SHALL be captured, and the FSM SHALL enter WAIT at the next edge.
REQ-006 stall_req SHALL be combinationally high in the presentation cycle and in every WAIT cycle without mem_ack; it SHALL be low in the mem_ack cycle.
REQ-007 In WAIT, mem_req SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL drive the captured values; mem_we SHALL be 0 for loads; mem_addr = {addr[31:2],2'b00}. Outside WAIT, mem_req=0.
REQ-008 On mem_ack in WAIT:
- FSM SHALL return to IDLE.
- For a load, data_WB SHALL update at that edge to extended mem_rdata: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; signed forms sign-extend, unsigned forms zero-extend.
- For a store, data_WB SHALL update to the captured addr.
REQ-009 Load-to-use latency SHALL be 1 cycle after mem_ack; with a 1-cycle memory, data_WB is valid 2 edges after presentation.
REQ-010 When in IDLE with no access presented: bubbleW=1 SHALL hold data_WB; otherwise flushW=1 SHALL load 0; otherwise data_WB <= addr.
REQ-011 bubbleW SHALL take priority over flushW, and flushW over an access; a flushed access SHALL issue no request.
REQ-012 flushW during WAIT SHALL NOT abort the memory transaction; the transaction SHALL complete and data_WB SHALL be written 0 instead of the result.
REQ-013 misalign SHALL pulse in the presentation cycle for: LW or store write_en=1111 with addr[1:0]!=0; LH/LHU or write_en 0011/1100 with addr[0]=1. The access SHALL still proceed.
REQ-014 A wait counter SHALL count WAIT cycles without mem_ack. When it reaches MAX_WAIT, the FSM SHALL return to IDLE, set timeout_err, write data_WB=0, and increment neither hit_cnt nor miss_cnt. A late mem_ack arriving in IDLE SHALL be ignored.
REQ-015 On mem_ack: miss_cnt SHALL increment if mem_miss=1, else hit_cnt SHALL increment. stall_cnt SHALL increment each cycle stall_req=1.
REQ-016 Counters SHALL saturate at all-ones.
REQ-017 cnt_clr SHALL zero all three counters and clear timeout_err; clear SHALL win over a simultaneous increment.

Reset
REQ-018 rst=1 at an edge SHALL force: IDLE; data_WB=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; misalign=0; timeout_err=0; all counters 0; wait counter 0.
REQ-019 Reset asserted during WAIT SHALL abandon the transaction without a counter update; stall_req SHALL be 0 while rst=1.

Verification
REQ-020 LB, addr=0x1003, mem_rdata=0x80FF_FF7F, ack after 3 cycles, mem_miss=1 -> data_WB=0xFFFF_FF80; stall_req high 3 cycles; miss_cnt=1; stall_cnt=3.
REQ-021 LHU, addr=0x2002, mem_rdata=0xBEEF_1234, 1-cycle ack, mem_miss=0 -> data_WB=0x0000_BEEF; hit_cnt=1.
REQ-022 Store write_en=1111, addr=0x3001 -> misalign pulses 1 cycle; mem_addr=0x3000; mem_we=1111; after ack, data_WB=0x3001.
REQ-023 flushW asserted in the second WAIT cycle of an LW, ack after 4 cycles -> mem_req held until ack; data_WB=0; hit_cnt or miss_cnt still increments.
REQ-024 MAX_WAIT=4, LW, no ack -> returns to IDLE after 4 WAIT cycles; timeout_err=1; data_WB=0; a late mem_ack changes nothing; cnt_clr then clears timeout_err.
REQ-025 ALU path, addr=0x55, bubbleW=1 and flushW=1 together -> data_WB holds its prior value; next cycle flushW only -> data_WB=0.
